// File: rtl/crc_frame_rx.sv
// crc_frame_rx: bit-serial frame receiver with an on-the-fly CRC check.
// A frame is BW payload bits followed by CRC_BW CRC bits, MSB first. The
// running polynomial remainder is updated per accepted bit. A frame passes
// when the remainder of the whole frame is zero. The payload and its pass
// flag are then held on a valid/ready port.
//
// Handshake: payload_out/crc_ok are valid while frame_valid=1 and remain
// stable until a rising edge where frame_valid=1 and frame_ready=1. That
// edge transfers the frame.
module crc_frame_rx #(
    parameter int                BW      = 40,
    parameter int                CRC_BW  = 8,
    parameter logic [CRC_BW-1:0] DIVISOR = 8'b0000_0111
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sof,
    input  logic          bit_in,
    input  logic          bit_valid,
    input  logic          frame_ready,
    output logic          frame_valid,
    output logic [BW-1:0] payload_out,
    output logic          crc_ok,
    output logic          busy,
    output logic          drop
);

    localparam int TOTAL = BW + CRC_BW;
    localparam int CW    = $clog2(TOTAL + 1);

    // Count value held when the final frame bit arrives, and payload length.
    localparam logic [CW-1:0] CNT_LAST = CW'(TOTAL - 1);
    localparam logic [CW-1:0] CNT_BW   = CW'(BW);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CW-1:0]       r_cnt;
    logic [CRC_BW-1:0]   r_rem;
    logic [BW-1:0]       r_payload;
    logic                r_crc_ok;
    logic                r_drop;

    logic                w_start;     // bit_in is bit 0 of a new frame
    logic                w_cont;      // bit_in continues the current frame
    logic                w_discard;   // bit_in is accepted but thrown away
    logic                w_last;      // bit_in completes the frame
    logic [CRC_BW-1:0]   w_rem_base;
    logic [CRC_BW-1:0]   w_rem_next;
    logic [BW-1:0]       w_payload_shift;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-bit classification: start, continue or discard.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_cont       = 1'b0;
        w_discard    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bit_valid) begin
                    if (sof) begin
                        w_start      = 1'b1;
                        w_next_state = S_RECV;
                    end else begin
                        w_discard = 1'b1;
                    end
                end
            end
            S_RECV: begin
                if (bit_valid) begin
                    if (sof) begin
                        // Abort and restart. The state stays in RECV.
                        w_start = 1'b1;
                    end else begin
                        w_cont = 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            w_next_state = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (frame_ready) begin
                    if (bit_valid && sof) begin
                        // Back-to-back: the next frame starts in the transfer cycle.
                        w_start      = 1'b1;
                        w_next_state = S_RECV;
                    end else begin
                        w_next_state = S_IDLE;
                        w_discard    = bit_valid;
                    end
                end else begin
                    w_discard = bit_valid;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        frame_valid = (r_state == S_HOLD);
        busy        = (r_state == S_RECV);
    end

    // One division step. A new frame restarts from a zero remainder.
    always_comb begin
        w_rem_base      = w_start ? '0 : r_rem;
        w_rem_next      = {w_rem_base[CRC_BW-2:0], bit_in}
                          ^ (w_rem_base[CRC_BW-1] ? DIVISOR : '0);
        w_payload_shift = {r_payload[BW-2:0], bit_in};
        w_last          = w_cont && (r_cnt == CNT_LAST);
    end

    // Datapath: bit counter, remainder, payload shift register, flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_payload <= '0;
            r_crc_ok  <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_drop <= w_discard;
            if (w_start) begin
                r_cnt     <= CW'(1);
                r_rem     <= w_rem_next;
                r_payload <= w_payload_shift;
            end else if (w_cont) begin
                r_cnt <= r_cnt + CW'(1);
                r_rem <= w_rem_next;
                // Only payload bits enter the shift register. CRC bits update only the remainder.
                if (r_cnt < CNT_BW) begin
                    r_payload <= w_payload_shift;
                end
                if (w_last) begin
                    r_crc_ok <= (w_rem_next == '0);
                end
            end else if ((r_state == S_HOLD) && frame_ready) begin
                r_cnt <= '0;
            end
        end
    end

    assign payload_out = r_payload;
    assign crc_ok      = r_crc_ok;
    assign drop        = r_drop;

endmodule
